// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for the iterative shift-add multiplier.
// Handshake: the master raises start with a/b valid; the slave accepts it only while busy=0,
// then raises busy until the job ends. done pulses for one enabled cycle with product valid,
// and product holds while idle until the next accepted start.
interface shift_add_mult_if #(
    parameter int n = 8
);
    logic             start;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*n-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned multiplier: one shift-left-by-one of the multiplicand and a
// conditional accumulate per enabled cycle, n cycles per product.
module shift_add_mult #(
    parameter int n = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    shift_add_mult_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [2*n-1:0]  mcand, mcand_next;
    logic [n-1:0]    mplier, mplier_next;
    logic [2*n-1:0]  acc, acc_next;
    logic [CW-1:0]   count, count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (en) begin
            state  <= state_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            acc    <= acc_next;
            count  <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        count_next  = count;
        case (state)
            IDLE: begin
                // acc is left alone here so the last product stays visible
                if (bus.start) begin
                    mcand_next  = {{n{1'b0}}, bus.a};
                    mplier_next = bus.b;
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (mplier[0]) acc_next = acc + mcand;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                count_next  = count + CW'(1);
                if (count == LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = acc;
    assign state_dbg   = state;
endmodule

// File: tb/tb_shift_add_mult.sv
// Randomised and directed bench for shift_add_mult: a driver issues jobs and queues a*b,
// an independent monitor pops and checks each done pulse for value and latency.
module tb_shift_add_mult;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [1:0]  state_dbg;

    shift_add_mult_if #(.n(N)) bus ();

    shift_add_mult #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int total_edges = 0;
    int en_edges = 0;
    int acc_total = 0;
    int done_total = 0;

    logic [2*N-1:0] exp_q[$];
    int             acc_q[$];

    always @(posedge clk) begin
        total_edges <= total_edges + 1;
        if (en && !rst) en_edges <= en_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the product is plain a*b; done must land n enabled edges after accept.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        tick();
        bus.start = 1'b0;
        exp_q.push_back((2*N)'(a) * (2*N)'(b));
        acc_q.push_back(en_edges);
        acc_total = total_edges;
        bus.a = N'($urandom);
        bus.b = N'($urandom);
    endtask

    task automatic wait_idle(input bit random_en);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            if (random_en) en = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
        end
        en = 1'b1;
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
        end
        tick();
    endtask

    logic prev_done = 1'b0;
    int   prev_edges = 0;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_single", 32'(prev_done && (en_edges != prev_edges)), 32'd0);
            if (!(prev_done && en_edges == prev_edges)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("product", 32'(bus.product), 32'(exp_q.pop_front()));
                    check("latency", 32'(en_edges - acc_q.pop_front()), 32'(N));
                    done_total = total_edges;
                end
            end
        end
        prev_done = bus.done;
        prev_edges = en_edges;
    end

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();

        // Basic job and product hold in IDLE
        issue(8'd13, 8'd11);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_idle(1'b0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_product", 32'(bus.product), 32'd143);
        repeat (3) tick();
        check("held_product", 32'(bus.product), 32'd143);

        // Boundary operands
        issue(8'd255, 8'd255);
        wait_idle(1'b0);
        check("max_product", 32'(bus.product), 32'hFE01);
        issue(8'd0, 8'd200);
        wait_idle(1'b0);
        check("zero_a", 32'(bus.product), 32'd0);
        issue(8'd200, 8'd0);
        wait_idle(1'b0);
        check("zero_b", 32'(bus.product), 32'd0);

        // start held high: one IDLE gap, then the second job is accepted
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd5;
        tick();
        exp_q.push_back(16'd15);
        acc_q.push_back(en_edges);
        bus.a = 8'd7;
        bus.b = 8'd9;
        repeat (N) tick();
        check("held_done", 32'(bus.done), 32'd1);
        tick();
        check("held_gap_busy", 32'(bus.busy), 32'd0);
        tick();
        exp_q.push_back(16'd63);
        acc_q.push_back(en_edges);
        check("held_second_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_idle(1'b0);
        check("held_second_product", 32'(bus.product), 32'd63);

        // Three-cycle stall mid-RUN
        issue(8'd6, 8'd7);
        repeat (2) tick();
        en = 1'b0;
        repeat (3) begin
            tick();
            check("stall_busy", 32'(bus.busy), 32'd1);
            check("stall_done", 32'(bus.done), 32'd0);
        end
        en = 1'b1;
        wait_idle(1'b0);
        check("stall_total_latency", 32'(done_total - acc_total), 32'd11);
        check("stall_product", 32'(bus.product), 32'd42);

        // Reset on the 4th RUN edge aborts the job
        issue(8'd100, 8'd100);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        acc_q.delete();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();
        issue(8'd2, 8'd2);
        wait_idle(1'b0);
        check("after_abort_product", 32'(bus.product), 32'd4);

        // Random operands with random enable stalls
        for (int i = 0; i < 500; i++) begin
            issue(N'($urandom), N'($urandom));
            wait_idle(1'b1);
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
